if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch stage and producer side of the IF/ID stage register; owns the PC and drives if_pc/if_instr into it.
- Fetches over a req/gnt/rvalid instruction-memory handshake and buffers results in a small FIFO.
- Obeys stall[1] back-pressure and redirects on flush (exception target) or branch (ID/EX target).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, entries of {pc, instr}; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  6  pipeline stall vector; bit 1 = 1 (Stop) means IF/ID will not accept this cycle.
- flush  in  1  exception/flush redirect.
- new_pc  in  32  flush target.
- branch_flag  in  1  taken-branch redirect.
- branch_target  in  32  branch target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; in order, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- if_pc_o  out  32  PC to IF/ID.
- if_instr_o  out  32  instruction to IF/ID.
- if_valid_o  out  1  FIFO head valid.

Behaviour:
- Reset (async) values: imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO empty, if_valid_o=0, if_pc_o=0, if_instr_o=0, state IDLE, discard=0.
- FSM states:
  - IDLE: if FIFO count + outstanding < FIFO_DEPTH, assert imem_req with imem_addr=fetch_pc and go to REQ.
  - REQ: hold imem_req=1 and imem_addr stable until imem_gnt. On gnt, fetch_pc += 4 and go to WAIT.
  - WAIT: imem_req=0. On imem_rvalid, either push {issued addr, imem_rdata} or drop it (if discard=1). Then clear discard. If room remains, go directly to REQ; otherwise go to IDLE.
- Outstanding requests: at most one. A slot is reserved at gnt, so a response never finds the FIFO full.
- Redirect priority is rst > flush > branch_flag; the target is new_pc or branch_target respectively.
- On a redirect edge:
  - fetch_pc <= target; FIFO cleared.
  - If a granted response is pending, or the cycle is in REQ, set discard=1.
  - A REQ in progress keeps its old address until gnt; that response is then dropped, and the next request uses the target.
  - An rvalid arriving on the redirect edge is dropped.
- Output:
  - Driven from the registered FIFO head; no combinational path from imem_* to if_*_o.
  - When the FIFO is empty: if_pc_o=0, if_instr_o=0 (ZeroWord bubble), if_valid_o=0.
- Pop happens when stall[1]=0 and the FIFO is non-empty.
  - Simultaneous pop and push in one cycle is legal; count is unchanged.
  - With stall[1]=1 the head holds, and fetching continues until the FIFO is full.
- Latency: with gnt in the same cycle as req and rvalid one cycle later, the instruction appears at if_*_o 2 cycles after req rises.
- Addresses wrap modulo 2^32 (0xFFFF_FFFC+4 = 0); no exception is raised.
- stall bits other than bit 1 are ignored.

Decomposition:
- Shared header define.v, holding:
  - RstEnable, Stop/NoStop, ZeroWord;
  - InstrAddrBus/InstrBus widths;
  - new PcStep (4) and FetchState encodings (IDLE/REQ/WAIT).
- Sub-module if_fifo:
  - Parameterized synchronous FIFO of {pc, instr} with push, pop, clear, count, head outputs.
  - Same clk/async rst.

Test Plan:
- Reset release with imem_gnt tied 1 and rvalid one cycle later:
  - imem_addr sequence 0x0, 0x4, 0x8;
  - if_pc_o=0x0 valid 2 cycles after req;
  - stream pops one entry per cycle with stall=0.
- stall[1]=1 for 6 cycles during streaming:
  - FIFO fills to 2 and imem_req drops;
  - head holds at 0x8;
  - on release, 0x8 then 0xC appear on consecutive cycles.
- flush with new_pc=0x100 while in WAIT for 0x10:
  - the 0x10 response is discarded;
  - next imem_addr=0x100;
  - if_valid_o=0 until 0x100 arrives.
- flush=1 and branch_flag=1 on the same cycle (new_pc=0x200, branch_target=0x300):
  - fetch resumes at 0x200.
- gnt delayed 3 cycles and a branch to 0x40 asserted during REQ for 0x20:
  - imem_addr stays 0x20 until gnt;
  - the response is dropped;
  - next request is 0x40.
- rst asserted mid-WAIT:
  - outputs go to reset values immediately (asynchronously);
  - the late rvalid is ignored;
  - the first request after release is RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: constants and types shared by the instruction-fetch stage.
//   - reset / stall polarity constants and the ZeroWord bubble value
//   - instruction address and data widths, PC step
//   - fetch FSM state encodings
//   - fetch_entry_t: one buffered {pc, instr} pair
package if_fetch_pkg;

  localparam logic RstEnable = 1'b1;
  localparam logic Stop      = 1'b1;
  localparam logic NoStop    = 1'b0;

  localparam int InstrAddrBus = 32;
  localparam int InstrBus     = 32;

  localparam logic [InstrBus-1:0]     ZeroWord = '0;
  localparam logic [InstrAddrBus-1:0] PcStep   = 32'd4;

  // Bit of the pipeline stall vector that belongs to the IF/ID register.
  localparam int StallIfBit = 1;

  localparam logic [1:0] FETCH_IDLE = 2'd0;
  localparam logic [1:0] FETCH_REQ  = 2'd1;
  localparam logic [1:0] FETCH_WAIT = 2'd2;

  typedef struct packed {
    logic [InstrAddrBus-1:0] pc;
    logic [InstrBus-1:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: small synchronous FIFO of {pc, instr} fetch results.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//   clear_i       drop every entry this edge (wins over push/pop)
//   push_i        write push_entry_i (ignored when full and not popping)
//   pop_i         retire the head entry (ignored when empty)
//   count_o       number of valid entries
//   empty_o       no valid entry
//   head_o        oldest entry, read from registered storage
module if_fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_entry_i,
  input  logic                   pop_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output fetch_entry_t           head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing reads it while count_q is zero.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage, producer side of the IF/ID register.
// Owns the PC, fetches over a req/gnt/rvalid memory handshake with at most
// one outstanding request, and buffers results in if_fetch_fifo.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   stall[5:0]               only bit 1 is used: IF/ID refuses this cycle
//   flush, new_pc            exception redirect (highest priority)
//   branch_flag, branch_target  taken-branch redirect
//   imem_req/addr/gnt        request channel, address held until gnt
//   imem_rvalid/rdata        in-order response channel
//   if_pc_o/instr_o/valid_o  registered FIFO head (zero bubble when empty)
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        if_valid_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic          discard_q, discard_d;

  logic          redirect;
  logic [31:0]   redirect_pc, next_pc;
  logic          push, pop, room, fifo_empty;
  logic [CW-1:0] fifo_count, count_after;
  fetch_entry_t  push_entry, head;
  logic          unused_bits;

  assign unused_bits = ^{stall[5:2], stall[0], new_pc[1:0], branch_target[1:0]};

  always_comb begin
    redirect    = flush | branch_flag;
    redirect_pc = flush ? {new_pc[31:2], 2'b00} : {branch_target[31:2], 2'b00};
    next_pc     = redirect ? redirect_pc : fetch_pc_q;

    // A redirect clears the FIFO, so neither pop nor push may happen then;
    // an rvalid landing on the redirect edge belongs to the old stream.
    pop  = (stall[StallIfBit] == NoStop) && !fifo_empty && !redirect;
    push = (state_q == FETCH_WAIT) && imem_rvalid && !discard_q && !redirect;

    // Occupancy after this edge; the next request may only start if the
    // slot it will need is guaranteed free when its response returns.
    count_after = redirect ? '0 : fifo_count + CW'(push) - CW'(pop);
    room        = count_after < CW'(FIFO_DEPTH);

    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    discard_d  = discard_q;

    case (state_q)
      FETCH_IDLE: begin
        if (room) begin
          state_d = FETCH_REQ;
          req_d   = 1'b1;
          addr_d  = next_pc;
        end
      end
      FETCH_REQ: begin
        req_d = 1'b1;
        if (imem_gnt) begin
          state_d = FETCH_WAIT;
          req_d   = 1'b0;
          // A stale request (redirected while waiting for gnt) must not
          // advance the PC: fetch_pc already holds the redirect target.
          if (!discard_q) fetch_pc_d = fetch_pc_q + PcStep;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
          if (room) begin
            state_d = FETCH_REQ;
            req_d   = 1'b1;
            addr_d  = next_pc;
          end else begin
            state_d = FETCH_IDLE;
          end
        end
      end
      default: begin
        state_d = FETCH_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      // Anything already issued (or being issued) belongs to the old path.
      if ((state_q == FETCH_REQ) || ((state_q == FETCH_WAIT) && !imem_rvalid))
        discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      discard_q  <= discard_d;
    end
  end

  // addr_q is held through WAIT, so it is the address of the response.
  assign push_entry.pc    = addr_q;
  assign push_entry.instr = imem_rdata;

  if_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (redirect),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (fifo_count),
    .empty_o      (fifo_empty),
    .head_o       (head)
  );

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign if_valid_o = !fifo_empty;
  assign if_pc_o    = fifo_empty ? ZeroWord : head.pc;
  assign if_instr_o = fifo_empty ? ZeroWord : head.instr;

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed test of if_fetch with a scoreboard.
// A memory responder answers requests with configurable gnt/rvalid delays.
// Expected granted addresses and expected consumed outputs are queued by the
// stimulus; two monitors pop and compare them as the DUT presents them.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_valid_o;

  int n_cmp  = 0;
  int n_fail = 0;

  int gnt_delay = 0;
  int rv_delay  = 1;

  logic [31:0] exp_req_q[$];
  logic [31:0] exp_out_q[$];

  always #5 clk = ~clk;

  if_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .if_valid_o    (if_valid_o)
  );

  // Memory contents: every word is a fixed function of its address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: decisions made 1 time unit after each rising edge.
  initial begin
    int          wait_cnt;
    int          pend_cnt;
    logic [31:0] pend_addr;
    wait_cnt    = 0;
    pend_cnt    = 0;
    pend_addr   = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = instr_of(pend_addr);
        end
      end
      imem_gnt = 1'b0;
      if (imem_req) begin
        if (wait_cnt >= gnt_delay) begin
          imem_gnt  = 1'b1;
          pend_addr = imem_addr;
          pend_cnt  = rv_delay;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Request monitor: every granted address must match the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && imem_req && imem_gnt) begin
        $display("req  addr=%h", imem_addr);
        if (exp_req_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL req_unexpected: got %h expected none", imem_addr);
        end else begin
          check("req_addr", imem_addr, exp_req_q.pop_front());
        end
      end
    end
  end

  // Output monitor: an entry is consumed when valid, not stalled, no redirect.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && if_valid_o && !stall[1] && !flush && !branch_flag) begin
        $display("out  pc=%h instr=%h", if_pc_o, if_instr_o);
        if (exp_out_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL out_unexpected: got pc %h expected none", if_pc_o);
        end else begin
          e = exp_out_q.pop_front();
          check("out_pc", if_pc_o, e);
          check("out_instr", if_instr_o, instr_of(e));
        end
      end
    end
  end

  initial begin
    stall         = '0;
    flush         = 1'b0;
    new_pc        = '0;
    branch_flag   = 1'b0;
    branch_target = '0;
    rst           = 1'b0;
    #1 rst        = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req",   {31'd0, imem_req},   32'd0);
    check("rst_addr",  imem_addr,           32'h0);
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_pc",    if_pc_o,             32'h0);
    check("rst_instr", if_instr_o,          32'h0);
    @(posedge clk);
    #2;
    // Cycle c is the interval after the c-th rising edge following release.
    for (int c = -1; c <= 50; c++) begin
      if (c > -1) begin
        @(posedge clk);
        #2;
      end
      case (c)
        -1: begin
          stall = 6'b111101;  // other stall bits must be ignored
          rst   = 1'b0;
          exp_req_q.push_back(32'h0);
          exp_req_q.push_back(32'h4);
          exp_req_q.push_back(32'h8);
          exp_req_q.push_back(32'hC);
          exp_out_q.push_back(32'h0);
          exp_out_q.push_back(32'h4);
        end
        5: begin
          stall = 6'b000010;
          exp_out_q.push_back(32'h8);
          exp_out_q.push_back(32'hC);
        end
        11: begin
          stall    = 6'b000000;
          rv_delay = 3;
          exp_req_q.push_back(32'h10);
        end
        13: begin
          flush    = 1'b1;
          new_pc   = 32'h100;
          rv_delay = 1;
          exp_req_q.push_back(32'h100);
          exp_req_q.push_back(32'h104);
          exp_req_q.push_back(32'h108);
          exp_out_q.push_back(32'h100);
        end
        14: flush = 1'b0;
        20: begin
          flush         = 1'b1;
          branch_flag   = 1'b1;
          new_pc        = 32'h200;
          branch_target = 32'h300;
          exp_req_q.push_back(32'h200);
          exp_req_q.push_back(32'h204);
          exp_out_q.push_back(32'h200);
        end
        21: begin
          flush       = 1'b0;
          branch_flag = 1'b0;
        end
        25: begin
          branch_flag   = 1'b1;
          branch_target = 32'h20;
          gnt_delay     = 3;
          exp_req_q.push_back(32'h20);
        end
        26: branch_flag = 1'b0;
        27: begin
          branch_flag   = 1'b1;
          branch_target = 32'h40;
          exp_req_q.push_back(32'h40);
          exp_req_q.push_back(32'h44);
          exp_req_q.push_back(32'h48);
          exp_out_q.push_back(32'h40);
        end
        28: branch_flag = 1'b0;
        30: gnt_delay = 0;
        34: rv_delay = 4;
        35: stall = 6'b000010;
        36: begin
          rst = 1'b1;
          #1;
          check("async_rst_req",   {31'd0, imem_req},   32'd0);
          check("async_rst_addr",  imem_addr,           32'h0);
          check("async_rst_valid", {31'd0, if_valid_o}, 32'd0);
          check("async_rst_pc",    if_pc_o,             32'h0);
          check("async_rst_instr", if_instr_o,          32'h0);
        end
        37: rv_delay = 1;
        40: begin
          rst   = 1'b0;
          stall = 6'b000000;
          exp_req_q.push_back(32'h0);
          exp_req_q.push_back(32'h4);
          exp_req_q.push_back(32'h8);
          exp_out_q.push_back(32'h0);
        end
        44: stall = 6'b000010;
        default: ;
      endcase

      @(negedge clk);
      if (c == 0) begin
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0);
      end
      if (c == 1) check("lat_c1_valid", {31'd0, if_valid_o}, 32'd0);
      if (c == 2) begin
        check("lat_c2_valid", {31'd0, if_valid_o}, 32'd1);
        check("lat_c2_pc", if_pc_o, 32'h0);
      end
      if (c >= 8 && c <= 10) begin
        check("full_req_low", {31'd0, imem_req}, 32'd0);
        check("full_valid", {31'd0, if_valid_o}, 32'd1);
        check("full_head_pc", if_pc_o, 32'h8);
      end
      if (c >= 14 && c <= 17) check("flush_bubble", {31'd0, if_valid_o}, 32'd0);
      if (c == 16) begin
        check("flush_req", {31'd0, imem_req}, 32'd1);
        check("flush_addr", imem_addr, 32'h100);
      end
      if (c == 22) begin
        check("prio_req", {31'd0, imem_req}, 32'd1);
        check("prio_addr", imem_addr, 32'h200);
      end
      if (c >= 26 && c <= 29) begin
        check("hold_req", {31'd0, imem_req}, 32'd1);
        check("hold_addr", imem_addr, 32'h20);
      end
      if (c == 31) begin
        check("branch_req", {31'd0, imem_req}, 32'd1);
        check("branch_addr", imem_addr, 32'h40);
      end
      if (c >= 37 && c <= 40) begin
        check("in_rst_req", {31'd0, imem_req}, 32'd0);
        check("in_rst_valid", {31'd0, if_valid_o}, 32'd0);
        check("in_rst_addr", imem_addr, 32'h0);
      end
      if (c == 41) begin
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'h0);
      end
      if (c >= 47) begin
        check("end_req_low", {31'd0, imem_req}, 32'd0);
        check("end_valid", {31'd0, if_valid_o}, 32'd1);
        check("end_head_pc", if_pc_o, 32'h4);
        check("end_head_instr", if_instr_o, instr_of(32'h4));
      end
    end

    check("req_left", 32'(exp_req_q.size()), 32'd0);
    check("out_left", 32'(exp_out_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
